// File: rtl/apb_master.sv
// APB initiator: turns a command/response handshake into one APB transfer at a time,
// with optional abort of transfers whose completer never raises pready.
module apb_master #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  m_psel,
    output logic                  m_penable,
    output logic                  m_pwrite,
    output logic [ADDR_W-1:0]     m_paddr,
    output logic [DATA_W-1:0]     m_pwdata,
    output logic [DATA_W/8-1:0]   m_pstrb,
    input  logic [DATA_W-1:0]     m_prdata,
    input  logic                  m_pready,
    input  logic                  m_pslverr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    // cmd_ready is a flop so it can read 0 in the cycle right after reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            m_psel      <= 1'b0;
            m_penable   <= 1'b0;
            m_pwrite    <= 1'b0;
            m_paddr     <= '0;
            m_pwdata    <= '0;
            m_pstrb     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        state     <= SETUP;
                        cmd_ready <= 1'b0;
                        m_psel    <= 1'b1;
                        m_pwrite  <= cmd_write;
                        m_paddr   <= cmd_addr;
                        m_pwdata  <= cmd_write ? cmd_wdata : '0;
                        m_pstrb   <= cmd_write ? cmd_strb : {STRB_W{1'b0}};
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    state     <= ACCESS;
                    m_penable <= 1'b1;
                end
                ACCESS: begin
                    // pready takes priority over the timeout limit on the same edge.
                    if (m_pready) begin
                        state       <= RESP;
                        m_psel      <= 1'b0;
                        m_penable   <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= m_pwrite ? '0 : m_prdata;
                        rsp_err     <= m_pslverr;
                        rsp_timeout <= 1'b0;
                    end else if (TIMEOUT > 0 && wait_cnt == CNT_LIMIT) begin
                        state       <= RESP;
                        m_psel      <= 1'b0;
                        m_penable   <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        wait_cnt  <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master: a cycle-stepped APB completer plus a transfer-level
// model predicting access length, response fields and bus contents.
module tb_apb_master;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [3:0]        cmd_strb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              m_psel;
    logic              m_penable;
    logic              m_pwrite;
    logic [ADDR_W-1:0] m_paddr;
    logic [DATA_W-1:0] m_pwdata;
    logic [3:0]        m_pstrb;
    logic [DATA_W-1:0] m_prdata;
    logic              m_pready;
    logic              m_pslverr;

    int checks   = 0;
    int failures = 0;

    apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
        .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [86:0] allOutputs();
        return {cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
                m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb};
    endfunction

    // One whole transfer, called at a negedge with the DUT expected idle and ready.
    task automatic applyStimulus(input bit wr, input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, input int waits, input bit slverr,
                                 input logic [31:0] rdata, input int rsp_delay, input bit hold_valid);
        bit          exp_to;
        bit          exp_err;
        bit          done;
        int          n_access;
        logic [31:0] exp_rdata;
        logic [48:0] exp_bus;

        exp_to    = (TIMEOUT > 0) && (waits >= TIMEOUT);
        n_access  = exp_to ? TIMEOUT : waits + 1;
        exp_rdata = (wr || exp_to) ? 32'h0 : rdata;
        exp_err   = exp_to || slverr;
        exp_bus   = {wr, addr, (wr ? wdata : 32'h0), (wr ? strb : 4'h0)};

        checkOutput("idle_ready", {cmd_ready, m_psel, m_penable, rsp_valid}, 4'b1000);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
        @(negedge sys_clk);

        cmd_valid = hold_valid;
        cmd_write = 1'($urandom);
        cmd_addr  = ADDR_W'($urandom);
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
        checkOutput("setup_ctrl", {m_psel, m_penable, cmd_ready, rsp_valid}, 4'b1000);
        checkOutput("setup_bus", {m_pwrite, m_paddr, m_pwdata, m_pstrb}, exp_bus);
        m_pready  = 1'b0;
        m_prdata  = $urandom;
        m_pslverr = 1'($urandom);

        for (int k = 0; k < n_access; k++) begin
            @(negedge sys_clk);
            checkOutput("access_ctrl", {m_psel, m_penable, cmd_ready, rsp_valid}, 4'b1100);
            checkOutput("access_bus", {m_pwrite, m_paddr, m_pwdata, m_pstrb}, exp_bus);
            done      = !exp_to && (k == waits);
            m_pready  = done;
            m_prdata  = done ? rdata : $urandom;
            m_pslverr = done ? slverr : 1'($urandom);
        end

        for (int d = 0; d <= rsp_delay; d++) begin
            @(negedge sys_clk);
            m_pready  = 1'b0;
            m_pslverr = 1'b0;
            checkOutput("resp_ctrl", {m_psel, m_penable, cmd_ready, rsp_valid}, 4'b0001);
            checkOutput("resp_rdata", rsp_rdata, exp_rdata);
            checkOutput("resp_flags", {rsp_err, rsp_timeout}, {exp_err, exp_to});
            checkOutput("resp_bus_hold", {m_pwrite, m_paddr, m_pwdata, m_pstrb}, exp_bus);
            rsp_ready = (d == rsp_delay);
        end

        @(negedge sys_clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        checkOutput("back_idle", {rsp_valid, cmd_ready, m_psel}, 3'b010);
    endtask

    task automatic resetMidAccess();
        checkOutput("rst_pre_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 12'h0A8;
        cmd_wdata = 32'h1234_5678;
        cmd_strb  = 4'hF;
        m_pready  = 1'b0;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        @(negedge sys_clk);
        checkOutput("rst_in_access", {m_psel, m_penable}, 2'b11);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        checkOutput("rst_all_zero", allOutputs(), 87'h0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        checkOutput("rst_release", {cmd_ready, rsp_valid, m_psel, m_penable}, 4'b1000);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b0;
        m_prdata  = '0;
        m_pready  = 1'b0;
        m_pslverr = 1'b0;

        repeat (3) @(negedge sys_clk);
        checkOutput("reset_outputs", allOutputs(), 87'h0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        checkOutput("reset_release", {cmd_ready, m_psel}, 2'b10);

        $display("[TB] directed transfers");
        applyStimulus(1'b1, 12'h004, 32'h0000_0001, 4'hF, 0, 1'b0, 32'hFFFF_FFFF, 0, 1'b0);
        applyStimulus(1'b0, 12'h010, 32'hAAAA_5555, 4'hF, 3, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);
        applyStimulus(1'b0, 12'h020, 32'h0, 4'h0, 0, 1'b1, 32'h0BAD_F00D, 0, 1'b0);
        applyStimulus(1'b1, 12'h024, 32'hCAFE_0001, 4'h3, 0, 1'b0, 32'h0, 0, 1'b0);
        applyStimulus(1'b0, 12'h030, 32'h0, 4'h0, 100, 1'b0, 32'h1111_2222, 0, 1'b0);
        applyStimulus(1'b0, 12'h034, 32'h0, 4'h0, TIMEOUT - 1, 1'b0, 32'h3333_4444, 0, 1'b0);
        applyStimulus(1'b1, 12'h038, 32'h5555_6666, 4'hC, 2, 1'b0, 32'h0, 5, 1'b1);
        applyStimulus(1'b0, 12'h03C, 32'h0, 4'h0, 1, 1'b0, 32'h7777_8888, 0, 1'b1);

        $display("[TB] reset during access");
        resetMidAccess();
        applyStimulus(1'b0, 12'hFFC, 32'h0, 4'h0, 0, 1'b0, 32'h8000_0001, 0, 1'b0);

        $display("[TB] random transfers");
        for (int t = 0; t < 40; t++) begin
            applyStimulus(1'($urandom), ADDR_W'($urandom), $urandom, 4'($urandom),
                          int'($urandom_range(0, 20)), 1'($urandom), $urandom,
                          int'($urandom_range(0, 3)), 1'($urandom));
            if ($urandom_range(0, 3) == 0) @(negedge sys_clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB initiator that turns simple command/response handshakes into APB transfers toward the timer's APB completer port (psel/penable/pwrite/paddr/pwdata/pstrb in; prdata/pready/pslverr out).
- Used by the bench and by an on-chip sequencer to program and poll timer registers.
- Drives one transfer at a time: SETUP, then ACCESS with wait states, then a response.
- A timeout aborts transfers that never complete.

Parameters:
- ADDR_W, 12, APB address width.
- DATA_W, 32, APB data width. The strobe width is DATA_W/8.
- TIMEOUT, 16, maximum number of ACCESS cycles without pready before abort. 0 disables the timeout.

Ports:
- sys_clk  in  1  clock; all logic on the rising edge.
- sys_rst_n  in  1  reset; synchronous, active-low.
- cmd_valid  in  1  a command is present.
- cmd_ready  out  1  the master accepts a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  write byte strobes.
- rsp_valid  out  1  a response is present.
- rsp_ready  in  1  the consumer accepts the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  pslverr was returned or a timeout occurred.
- rsp_timeout  out  1  the transfer was aborted by timeout.
- m_psel, m_penable, m_pwrite  out  1 each  APB control.
- m_paddr  out  ADDR_W  APB address.
- m_pwdata  out  DATA_W  APB write data.
- m_pstrb  out  DATA_W/8  APB strobes.
- m_prdata  in  DATA_W  APB read data.
- m_pready  in  1  APB ready.
- m_pslverr  in  1  APB error.

Behaviour:
- Reset: sys_rst_n low at a rising edge forces state IDLE. All outputs are 0, including the registered m_paddr, m_pwdata, m_pstrb, m_pwrite, rsp_rdata, rsp_err and rsp_timeout. The timeout counter is 0.
  - Reset mid-transfer abandons the transfer. No response is produced.
  - m_psel is 0 in the cycle after the reset edge.
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered or decoded from the state only; there is no combinational path from m_* inputs to m_* outputs.
- IDLE:
  - cmd_ready=1, m_psel=0, m_penable=0.
  - On cmd_valid at an edge: latch the command into the m_paddr, m_pwdata, m_pwrite and m_pstrb registers, then go to SETUP.
  - For reads, m_pstrb is 0 and m_pwdata is 0.
  - cmd_ready is 0 in every other state.
- SETUP: exactly one cycle with m_psel=1 and m_penable=0, then unconditionally go to ACCESS.
- ACCESS:
  - m_psel=1, m_penable=1.
  - Address, data, strobe and pwrite stay stable from SETUP until the transfer ends.
  - If m_pready=1 at an edge:
    - rsp_rdata <= m_prdata for reads, or 0 for writes.
    - rsp_err <= m_pslverr; rsp_timeout <= 0.
    - Go to RESP.
  - If m_pready=0: increment the wait counter. When the counter equals TIMEOUT-1 (TIMEOUT>0) and pready is still 0:
    - Go to RESP with rsp_err=1, rsp_timeout=1 and rsp_rdata=0.
    - m_psel and m_penable drop to 0 in the next cycle.
  - m_pready together with the timeout limit in the same edge: pready wins and the transfer completes normally.
- RESP:
  - m_psel=0, m_penable=0, rsp_valid=1.
  - rsp_rdata, rsp_err and rsp_timeout hold until rsp_ready=1 at an edge, then go to IDLE and clear the counter.
  - rsp_valid must not drop without rsp_ready.
- Latency:
  - Command accepted at edge N gives SETUP in cycle N..N+1 and ACCESS from N+1.
  - With zero wait states (pready=1 at edge N+2), rsp_valid=1 from N+2.
  - Minimum 4 cycles per transfer including the return to IDLE (rsp_ready tied to 1).
  - Each wait state adds one cycle.
- m_paddr, m_pwdata and m_pstrb hold their last values in IDLE and RESP. m_pwrite holds as well.
- Wait counter: width clog2(TIMEOUT+1), saturating. It is not used when TIMEOUT=0, and a transfer may then wait indefinitely.

Test Plan:
- Reset then write: cmd {write=1, addr=0x004, wdata=0x0000_0001, strb=0xF}, pready=1 → SETUP cycle with psel=1, penable=0; next cycle penable=1; rsp_valid with rsp_err=0, rsp_rdata=0; total 4 cycles.
- Read with 3 wait states: cmd {write=0, addr=0x010}, pready low for 3 ACCESS cycles, then prdata=0xDEAD_BEEF → paddr stable throughout, pstrb=0, rsp_rdata=0xDEAD_BEEF, rsp_valid 3 cycles later than the zero-wait case.
- Error: pslverr=1 together with pready → rsp_err=1, rsp_timeout=0; the next command is accepted normally.
- Timeout: TIMEOUT=16, pready held 0 → exactly 16 ACCESS cycles, then psel=0 and rsp {err=1, timeout=1, rdata=0}. A variant asserts pready in the 16th cycle and gets a normal completion.
- Backpressure and back-to-back: rsp_ready=0 for 5 cycles → rsp fields stable, cmd_ready=0, psel=0. Then rsp_ready=1 with cmd_valid held → the next SETUP starts 2 cycles later.
- Reset mid-ACCESS: assert sys_rst_n=0 while penable=1 → next cycle psel=0, penable=0, rsp_valid=0, all m_* outputs 0, cmd_ready=1 after release.
